// File: rtl/game_pkg.sv
// Shared constants and types for the Bulls-and-Cows keypad and game control blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 3;

    localparam logic [DIGIT_W-1:0] KEY_BKSP = 4'hA;
    localparam logic [DIGIT_W-1:0] KEY_CLR  = 4'hB;
    localparam logic [DIGIT_W-1:0] KEY_ENT  = 4'hC;

    typedef enum logic [1:0] {
        S_ENTRY  = 2'd0,
        S_FULL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector on the keypad's key-held level; one strobe per press.
// Latency: strobe is high the cycle after key_valid_i first goes high.
// Backpressure: none; a held key never re-strobes until it is released.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid_i,
    output logic key_stb_o
);

    logic valid_d_q;
    logic stb_q;

    // Remember last cycle's level and register the rising-edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d_q <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            valid_d_q <= key_valid_i;
            stb_q     <= key_valid_i & ~valid_d_q;
        end
    end

    assign key_stb_o = stb_q;

endmodule

// File: rtl/guess_entry.sv
// Collects keypad digits into a 3-digit guess with backspace/clear/enter and emits it.
// Latency: key press to buffer update 2 cycles; enter strobe to oNumRdy 1 cycle.
// Backpressure: none; keys arriving while a guess is being committed are dropped with err.
module guess_entry #(
    parameter logic [3:0] KEY_BKSP     = game_pkg::KEY_BKSP,
    parameter logic [3:0] KEY_CLR      = game_pkg::KEY_CLR,
    parameter logic [3:0] KEY_ENT      = game_pkg::KEY_ENT,
    parameter bit         ALLOW_REPEAT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] oNum1,
    output logic [3:0] oNum2,
    output logic [3:0] oNum3,
    output logic       oNumRdy,
    output logic [3:0] pend1,
    output logic [3:0] pend2,
    output logic [3:0] pend3,
    output logic [1:0] entry_cnt,
    output logic       err
);

    import game_pkg::*;

    logic                                  key_stb;
    logic [DIGIT_W-1:0]                    code_q;
    state_t                                state_q, state_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    pend_q, pend_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    onum_q, onum_d;
    logic [1:0]                            cnt_q, cnt_d;
    logic                                  err_q, err_d;
    logic                                  rdy_q, rdy_d;
    logic                                  dup;

    key_edge u_key_edge (
        .clk         (clk),
        .rst_n       (reset),
        .key_valid_i (key_valid),
        .key_stb_o   (key_stb)
    );

    // Delay the code by one cycle so it lines up with the registered strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= '0;
        end else begin
            code_q <= key_code;
        end
    end

    // Duplicate check against occupied slots only; empty slots never match.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((2'(i) < cnt_q) && (pend_q[i] == code_q)) begin
                dup = 1'b1;
            end
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ENTRY;
            pend_q  <= '0;
            onum_q  <= '0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            onum_q  <= onum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: key decode, buffer edits and commit sequencing.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        onum_d  = onum_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rdy_d   = 1'b0;
        case (state_q)
            S_ENTRY, S_FULL: begin
                if (key_stb) begin
                    if (code_q <= 4'd9) begin
                        if ((state_q == S_FULL) || (!ALLOW_REPEAT && dup)) begin
                            err_d = 1'b1;
                        end else begin
                            pend_d[cnt_q] = code_q;
                            cnt_d         = cnt_q + 2'd1;
                            if (cnt_q == 2'd2) begin
                                state_d = S_FULL;
                            end
                        end
                    end else if (code_q == KEY_BKSP) begin
                        if (cnt_q != 2'd0) begin
                            pend_d[cnt_q - 2'd1] = '0;
                            cnt_d                = cnt_q - 2'd1;
                            state_d              = S_ENTRY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (code_q == KEY_CLR) begin
                        pend_d  = '0;
                        cnt_d   = 2'd0;
                        state_d = S_ENTRY;
                    end else if (code_q == KEY_ENT) begin
                        if (state_q == S_FULL) begin
                            state_d = S_COMMIT;
                            onum_d  = pend_q;
                            rdy_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                // The commit cycle empties the buffer; any key arriving now is lost.
                pend_d  = '0;
                cnt_d   = 2'd0;
                state_d = S_ENTRY;
                err_d   = key_stb;
            end
            default: begin
                state_d = S_ENTRY;
            end
        endcase
    end

    assign oNum1     = onum_q[0];
    assign oNum2     = onum_q[1];
    assign oNum3     = onum_q[2];
    assign oNumRdy   = rdy_q;
    assign pend1     = pend_q[0];
    assign pend2     = pend_q[1];
    assign pend3     = pend_q[2];
    assign entry_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: two instances (repeats forbidden / allowed) on shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_guess_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;

    logic [3:0] a_n1, a_n2, a_n3, a_p1, a_p2, a_p3;
    logic       a_rdy, a_err;
    logic [1:0] a_cnt;
    logic [3:0] b_n1, b_n2, b_n3, b_p1, b_p2, b_p3;
    logic       b_rdy, b_err;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    guess_entry #(.ALLOW_REPEAT(1'b0)) u_norep (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .oNum1(a_n1), .oNum2(a_n2), .oNum3(a_n3), .oNumRdy(a_rdy),
        .pend1(a_p1), .pend2(a_p2), .pend3(a_p3), .entry_cnt(a_cnt), .err(a_err)
    );

    guess_entry #(.ALLOW_REPEAT(1'b1)) u_rep (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .oNum1(b_n1), .oNum2(b_n2), .oNum3(b_n3), .oNumRdy(b_rdy),
        .pend1(b_p1), .pend2(b_p2), .pend3(b_p3), .entry_cnt(b_cnt), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffer is a short list of digits; a press counts once and is acted on
    // two clock edges after the key first reads as held.
    bit  m_prev, m_stb;
    int  m_code;
    int  msz    [2];
    int  mbuf   [2][3];
    bit  mcommit[2];
    bit  e_err  [2];
    bit  e_rdy  [2];
    int  e_num  [2][3];
    bit  s_stb;
    int  s_code;

    task automatic model_step(input int v, input bit stb, input int code);
        bit found;
        e_err[v] = 1'b0;
        e_rdy[v] = 1'b0;
        if (mcommit[v]) begin
            msz[v] = 0;
            for (int i = 0; i < 3; i++) mbuf[v][i] = 0;
            mcommit[v] = 1'b0;
            if (stb) e_err[v] = 1'b1;
        end else if (stb) begin
            if (code < 10) begin
                found = 1'b0;
                for (int i = 0; i < msz[v]; i++) if (mbuf[v][i] == code) found = 1'b1;
                if (msz[v] == 3 || (v == 0 && found)) e_err[v] = 1'b1;
                else begin
                    mbuf[v][msz[v]] = code;
                    msz[v]++;
                end
            end else if (code == 10) begin
                if (msz[v] > 0) begin
                    msz[v]--;
                    mbuf[v][msz[v]] = 0;
                end else e_err[v] = 1'b1;
            end else if (code == 11) begin
                msz[v] = 0;
                for (int i = 0; i < 3; i++) mbuf[v][i] = 0;
            end else if (code == 12) begin
                if (msz[v] == 3) begin
                    for (int i = 0; i < 3; i++) e_num[v][i] = mbuf[v][i];
                    e_rdy[v]   = 1'b1;
                    mcommit[v] = 1'b1;
                end else e_err[v] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_prev = 1'b0; m_stb = 1'b0; m_code = 0;
            for (int v = 0; v < 2; v++) begin
                msz[v] = 0; mcommit[v] = 1'b0; e_err[v] = 1'b0; e_rdy[v] = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    mbuf[v][i] = 0; e_num[v][i] = 0;
                end
            end
        end else begin
            s_stb  = m_stb;
            s_code = m_code;
            m_stb  = key_valid && !m_prev;
            m_prev = key_valid;
            m_code = int'(key_code);
            for (int v = 0; v < 2; v++) model_step(v, s_stb, s_code);
        end
    end

    function automatic logic [31:0] exp_vec(input int v);
        return {4'h0, 4'(e_num[v][0]), 4'(e_num[v][1]), 4'(e_num[v][2]), e_rdy[v],
                4'(mbuf[v][0]), 4'(mbuf[v][1]), 4'(mbuf[v][2]), 2'(msz[v]), e_err[v]};
    endfunction

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("norep_outputs", {4'h0, a_n1, a_n2, a_n3, a_rdy, a_p1, a_p2, a_p3, a_cnt, a_err}, exp_vec(0));
            chk("rep_outputs",   {4'h0, b_n1, b_n2, b_n3, b_rdy, b_p1, b_p2, b_p3, b_cnt, b_err}, exp_vec(1));
        end
    end

    // Pulse counters and last committed guess, for the hand-written expectations.
    int          rdy_a = 0, rdy_b = 0, err_a = 0, err_b = 0;
    logic [11:0] last_a = '0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (a_rdy) begin rdy_a++; last_a = {a_n1, a_n2, a_n3}; end
            if (b_rdy) rdy_b++;
            if (a_err) err_a++;
            if (b_err) err_b++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] code, input int hold = 1, input int gap = 3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int ea, eb, ra, rb;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle(3);
        chk("reset_zero", {a_n1, a_n2, a_n3, a_rdy, a_p1, a_p2, a_p3, a_cnt, a_err}, 32'd0);
        reset = 1'b1;
        idle(2);

        // Long hold yields a single press.
        ea = err_a;
        press(4'd5, 20, 3);
        idle(2);
        chk("hold_pend1", a_p1, 4'd5);
        chk("hold_cnt", a_cnt, 2'd1);
        chk("hold_no_err", err_a - ea, 0);
        press(4'hB);

        // Full entry and commit.
        ra = rdy_a;
        press(4'd1); press(4'd2); press(4'd3); press(4'hC);
        idle(2);
        chk("commit_pulses", rdy_a - ra, 1);
        chk("commit_value", last_a, 12'h123);
        chk("commit_cleared", {a_p1, a_p2, a_p3, a_cnt}, 14'd0);
        chk("commit_held", {a_n1, a_n2, a_n3}, 12'h123);

        // Repeated digit.
        ea = err_a; eb = err_b;
        press(4'd4); press(4'd4);
        idle(2);
        chk("repeat_err_norep", err_a - ea, 1);
        chk("repeat_err_rep", err_b - eb, 0);
        chk("repeat_cnt_norep", a_cnt, 2'd1);
        chk("repeat_cnt_rep", b_cnt, 2'd2);
        press(4'hB);

        // Overflow, backspace, re-enter.
        ea = err_a;
        press(4'd7); press(4'd8); press(4'd9); press(4'd6);
        idle(2);
        chk("full_err", err_a - ea, 1);
        press(4'hA); press(4'd6); press(4'hC);
        idle(2);
        chk("bksp_commit", last_a, 12'h786);

        // Empty-buffer keys.
        ea = err_a;
        press(4'hC); press(4'hA);
        idle(2);
        chk("empty_ent_bksp_err", err_a - ea, 2);
        ea = err_a;
        press(4'hB); press(4'hE);
        idle(2);
        chk("clr_ignored_no_err", err_a - ea, 0);
        chk("clr_ignored_cnt", a_cnt, 2'd0);

        // Reset mid-entry.
        ra = rdy_a;
        press(4'd1); press(4'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_reset", {a_n1, a_n2, a_n3, a_rdy, a_p1, a_p2, a_p3, a_cnt, a_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        chk("reset_no_rdy", rdy_a - ra, 0);
        press(4'd3); press(4'd4); press(4'd5); press(4'hC);
        idle(2);
        chk("post_reset_commit", last_a, 12'h345);
        chk("post_reset_rdy", rdy_a - ra, 1);

        // Randomized presses, checked every cycle by the model.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] c;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      c = 4'($urandom_range(0, 9));
            else if (sel < 70) c = 4'hC;
            else if (sel < 82) c = 4'hA;
            else if (sel < 90) c = 4'hB;
            else               c = 4'($urandom_range(13, 15));
            press(c, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            if ($urandom_range(0, 49) == 0) begin
                @(negedge clk);
                reset = 1'b0;
                idle(int'($urandom_range(1, 2)));
                reset = 1'b1;
            end
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
